sisc_regfile: RTL and testbench

Register file stage of the SISC datapath, directly downstream of the 4-bit write-address select mux. It holds 16 general registers, provides two combinational read ports for the operand fetch, and accepts one write-back per cycle at the address the mux selects. A per-register pending-write scoreboard lets the control unit stall operand reads whose producer has issued but not yet written back.

---
 rtl/sisc_pkg.sv | 25 ++
 rtl/sisc_regfile_if.sv | 34 +++
 rtl/sisc_rf_scoreboard.sv | 54 +++++
 rtl/sisc_regfile.sv | 47 ++++
 tb/tb_sisc_regfile.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC datapath types and constants.
// Register file geometry, address/data typedefs, pending-count helper.
package sisc_pkg;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int NREG = 1 << AW;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;
    typedef logic [AW:0]   pend_cnt_t;

    localparam reg_addr_t R0 = '0;

    // Bit 0 is held clear by the scoreboard, so counting it is harmless.
    function automatic pend_cnt_t pend_count(input logic [NREG-1:0] v);
        pend_cnt_t c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/sisc_regfile_if.sv
// Operand-fetch / write-back / issue bundle of the SISC register file.
// master: control + write-back side; slave: the register file.
interface sisc_regfile_if;
    import sisc_pkg::*;

    reg_addr_t rd_sel_a;
    reg_addr_t rd_sel_b;
    logic      use_a;
    logic      use_b;
    word_t     rsa;
    word_t     rsb;
    reg_addr_t wr_sel;
    word_t     wr_data;
    logic      rf_we;
    logic      iss_vld;
    reg_addr_t iss_dst;
    logic      stall;
    pend_cnt_t pend_cnt;

    modport master (
        output rd_sel_a, rd_sel_b, use_a, use_b,
        output wr_sel, wr_data, rf_we,
        output iss_vld, iss_dst,
        input  rsa, rsb, stall, pend_cnt
    );

    modport slave (
        input  rd_sel_a, rd_sel_b, use_a, use_b,
        input  wr_sel, wr_data, rf_we,
        input  iss_vld, iss_dst,
        output rsa, rsb, stall, pend_cnt
    );

endinterface

// File: rtl/sisc_rf_scoreboard.sv
// Pending-write scoreboard: per-register pending bits, registered count, stall.
// Ports: issue (iss_vld/iss_dst), write-back (rf_we/wr_sel), reads, stall, pend_cnt.
module sisc_rf_scoreboard
    import sisc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_f,
    input  logic      iss_vld,
    input  reg_addr_t iss_dst,
    input  logic      rf_we,
    input  reg_addr_t wr_sel,
    input  reg_addr_t rd_sel_a,
    input  reg_addr_t rd_sel_b,
    input  logic      use_a,
    input  logic      use_b,
    output logic      stall,
    output pend_cnt_t pend_cnt
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            haz_a;
    logic            haz_b;

    // Set is applied after clear: a new producer issued on the same
    // edge as the old one's write-back keeps the register pending.
    always_comb begin
        pend_nxt = pend;
        if (rf_we && wr_sel != R0) begin
            pend_nxt[wr_sel] = 1'b0;
        end
        if (iss_vld && iss_dst != R0) begin
            pend_nxt[iss_dst] = 1'b1;
        end
        pend_nxt[R0] = 1'b0;
    end

    // Count comes from the same next-state vector so it never lags.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= pend_count(pend_nxt);
        end
    end

    // A write-back landing this cycle satisfies the read via bypass.
    assign haz_a = pend[rd_sel_a] && !(rf_we && wr_sel == rd_sel_a);
    assign haz_b = pend[rd_sel_b] && !(rf_we && wr_sel == rd_sel_b);
    assign stall = (use_a && haz_a) || (use_b && haz_b);

endmodule

// File: rtl/sisc_regfile.sv
// SISC register file: 16 x 32 storage, two bypassed read ports, one write.
// Ports: clk, rst_f (async, active-low), rf (slave bundle incl. stall/pend_cnt).
module sisc_regfile
    import sisc_pkg::*;
(
    input logic          clk,
    input logic          rst_f,
    sisc_regfile_if.slave rf
);

    word_t regs [NREG];
    logic  wr_en;

    // R0 is never written, so it stays at its reset value of zero.
    assign wr_en = rf.rf_we && (rf.wr_sel != R0);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rf.wr_sel] <= rf.wr_data;
        end
    end

    assign rf.rsa = (wr_en && rf.wr_sel == rf.rd_sel_a) ?
                    rf.wr_data : regs[rf.rd_sel_a];
    assign rf.rsb = (wr_en && rf.wr_sel == rf.rd_sel_b) ?
                    rf.wr_data : regs[rf.rd_sel_b];

    sisc_rf_scoreboard u_sb (
        .clk      (clk),
        .rst_f    (rst_f),
        .iss_vld  (rf.iss_vld),
        .iss_dst  (rf.iss_dst),
        .rf_we    (rf.rf_we),
        .wr_sel   (rf.wr_sel),
        .rd_sel_a (rf.rd_sel_a),
        .rd_sel_b (rf.rd_sel_b),
        .use_a    (rf.use_a),
        .use_b    (rf.use_b),
        .stall    (rf.stall),
        .pend_cnt (rf.pend_cnt)
    );

endmodule

// File: tb/tb_sisc_regfile.sv
// Self-checking bench for sisc_regfile.
// Model state + expectation queue; each scenario task compares inline.
module tb_sisc_regfile;
    import sisc_pkg::*;

    logic clk   = 1'b0;
    logic rst_f = 1'b0;

    sisc_regfile_if rf ();

    sisc_regfile dut (
        .clk   (clk),
        .rst_f (rst_f),
        .rf    (rf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        word_t     rsa;
        word_t     rsb;
        logic      stall;
        pend_cnt_t cnt;
    } obs_t;

    obs_t  exp_q[$];
    obs_t  e;
    obs_t  o;
    word_t mregs [NREG];
    logic  mpend [NREG];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic obs_t model_out();
        obs_t r;
        logic ha;
        logic hb;
        int   c;
        r.rsa = (rf.rf_we && rf.wr_sel == rf.rd_sel_a && rf.rd_sel_a != 0)
                ? rf.wr_data : mregs[rf.rd_sel_a];
        r.rsb = (rf.rf_we && rf.wr_sel == rf.rd_sel_b && rf.rd_sel_b != 0)
                ? rf.wr_data : mregs[rf.rd_sel_b];
        ha = mpend[rf.rd_sel_a] && !(rf.rf_we && rf.wr_sel == rf.rd_sel_a);
        hb = mpend[rf.rd_sel_b] && !(rf.rf_we && rf.wr_sel == rf.rd_sel_b);
        r.stall = (rf.use_a && ha) || (rf.use_b && hb);
        c = 0;
        for (int i = 1; i < NREG; i++) c += int'(mpend[i]);
        r.cnt = pend_cnt_t'(c);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            mregs[i] = '0;
            mpend[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge();
        if (rf.rf_we && rf.wr_sel != 0) begin
            mregs[rf.wr_sel] = rf.wr_data;
            mpend[rf.wr_sel] = 1'b0;
        end
        if (rf.iss_vld && rf.iss_dst != 0) mpend[rf.iss_dst] = 1'b1;
    endfunction

    task automatic drive(input reg_addr_t ra, input reg_addr_t rb,
                         input logic ua, input logic ub,
                         input logic we, input reg_addr_t ws,
                         input word_t wd,
                         input logic iv, input reg_addr_t id);
        rf.rd_sel_a = ra;
        rf.rd_sel_b = rb;
        rf.use_a    = ua;
        rf.use_b    = ub;
        rf.rf_we    = we;
        rf.wr_sel   = ws;
        rf.wr_data  = wd;
        rf.iss_vld  = iv;
        rf.iss_dst  = id;
        exp_q.push_back(model_out());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_f) model_edge();
    endtask

    task automatic test_reset();
        model_reset();
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            drive(reg_addr_t'(i), reg_addr_t'(NREG - 1 - i), 1'b1, 1'b1,
                  1'b0, 4'd0, 32'h0, 1'b1, reg_addr_t'(i));
            #1;
            e = exp_q.pop_front();
            o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_rd%0d: got %h want %h", i, o, e);
            end
            tick();
        end
        @(negedge clk);
        rst_f = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset_release: got %h want %h", o, e);
        end
        tick();
    endtask

    task automatic test_write_bypass();
        reg_addr_t ra [4] = '{4'd5, 4'd5, 4'd0, 4'd0};
        reg_addr_t rb [4] = '{4'd0, 4'd5, 4'd5, 4'd5};
        logic      we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        reg_addr_t ws [4] = '{4'd5, 4'd0, 4'd0, 4'd0};
        word_t     wd [4] = '{32'hDEADBEEF, 32'h0, 32'h1234, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(ra[i], rb[i], 1'b1, 1'b1, we[i], ws[i], wd[i],
                  1'b0, 4'd0);
            #1;
            e = exp_q.pop_front();
            o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wr_bypass%0d: got %h want %h", i, o, e);
            end
            tick();
        end
    endtask

    task automatic test_stall_clear();
        // issue R3; read with use_a; read with use_b; write-back; settle
        logic ua [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic ub [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic we [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic iv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(4'd3, 4'd3, ua[i], ub[i], we[i], 4'd3, 32'h55,
                  iv[i], 4'd3);
            #1;
            e = exp_q.pop_front();
            o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall_clr%0d: got %h want %h", i, o, e);
            end
            tick();
        end
    endtask

    task automatic test_same_edge();
        @(negedge clk);
        drive(4'd7, 4'd0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h0000_0777,
              1'b1, 4'd7);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL same_edge_pre: got %h want %h", o, e);
        end
        tick();
        @(negedge clk);
        drive(4'd7, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL same_edge_post: got %h want %h", o, e);
        end
        tick();
    endtask

    task automatic test_async_reset();
        reg_addr_t dst [3] = '{4'd2, 4'd4, 4'd6};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(4'd9, 4'd2, 1'b0, 1'b1, i == 2, 4'd9, 32'hA5A5A5A5,
                  1'b1, dst[i]);
            #1;
            e = exp_q.pop_front();
            o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL arst_fill%0d: got %h want %h", i, o, e);
            end
            tick();
        end
        @(negedge clk);
        drive(4'd9, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL arst_before: got %h want %h", o, e);
        end
        #1;
        rst_f = 1'b0;
        model_reset();
        exp_q.push_back(model_out());
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL arst_held: got %h want %h", o, e);
        end
        tick();
        @(negedge clk);
        rst_f = 1'b1;
        drive(4'd9, 4'd7, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL arst_after: got %h want %h", o, e);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int d = 1; d <= NREG + 1; d++) begin
            @(negedge clk);
            // d==16 issues R0, d==17 reads a pending reg with use_a
            drive(reg_addr_t'(d == NREG + 1 ? 4 : d % NREG), 4'd0,
                  d == NREG + 1, 1'b0, 1'b0, 4'd0, 32'h0,
                  d <= NREG, reg_addr_t'(d % NREG));
            #1;
            e = exp_q.pop_front();
            o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fill%0d: got %h want %h", d, o, e);
            end
            tick();
        end
        @(negedge clk);
        drive(4'd1, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        #1;
        e = exp_q.pop_front();
        o = {rf.rsa, rf.rsb, rf.stall, rf.pend_cnt};
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL fill_full: got %h want %h", o, e);
        end
        if (e.cnt !== pend_cnt_t'(15)) begin
            n_bad++;
            $display("FAIL fill_model_cnt: got %0d want 15", e.cnt);
        end
    endtask

    initial begin
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
        void'(exp_q.pop_front());
        test_reset();
        test_write_bypass();
        test_stall_clear();
        test_same_edge();
        test_async_reset();
        test_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
